// File: rtl/mul_chain_seq_if.sv
// Operand-in / product-out handshake bundle for mul_chain_seq.
interface mul_chain_seq_if #(
  parameter int TAG_W = 8,
  parameter int CNT_W = 5
);
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_tag, in_last, in_valid, out_ready,
    output in_ready, out_data, out_tag, out_count, out_ovf, out_valid
  );
  modport master (
    output in_data, in_tag, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_tag, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/mul_chain_seq.sv
// Sequential fp32 product of an operand stream through a 3-stage multiplier.
// Optional MUL_CHAIN_ZERO_SKIP_EN: bypass the multiplier while the accumulator is zero.
module mul_3_stage_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_op,
  output logic        out_valid,
  output logic [31:0] out_res
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic              s, nan, inf, zero;
    logic signed [10:0] e;
    logic [23:0]       ma, mb;
  } s1_t;
  typedef struct packed {
    logic              s, nan, inf, zero;
    logic signed [10:0] e;
    logic [47:0]       p;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [31:0] res_d, res_q;

  assign vld_pipe[0] = in_valid;

  // Subnormal inputs and results are flushed to signed zero.
  always_comb begin
    logic [7:0] ea, eb;
    logic za, zb, ia, ib, na, nb;
    ea = in_op[62:55];
    eb = in_op[30:23];
    za = (ea == 8'h00);
    zb = (eb == 8'h00);
    ia = (ea == 8'hFF) && (in_op[54:32] == 23'd0);
    ib = (eb == 8'hFF) && (in_op[22:0] == 23'd0);
    na = (ea == 8'hFF) && (in_op[54:32] != 23'd0);
    nb = (eb == 8'hFF) && (in_op[22:0] != 23'd0);
    s1_d      = '0;
    s1_d.s    = in_op[63] ^ in_op[31];
    s1_d.nan  = na | nb | (ia & zb) | (ib & za);
    s1_d.inf  = (ia | ib) & ~s1_d.nan;
    s1_d.zero = (za | zb) & ~s1_d.nan;
    s1_d.e    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    s1_d.ma   = {1'b1, in_op[54:32]};
    s1_d.mb   = {1'b1, in_op[22:0]};
  end

  always_comb begin
    s2_d      = '0;
    s2_d.s    = s1_q.s;
    s2_d.nan  = s1_q.nan;
    s2_d.inf  = s1_q.inf;
    s2_d.zero = s1_q.zero;
    s2_d.e    = s1_q.e;
    s2_d.p    = {24'd0, s1_q.ma} * {24'd0, s1_q.mb};
  end

  // Normalise, round to nearest even, then pack with overflow/underflow clamps.
  always_comb begin
    logic [22:0] m;
    logic        g, st;
    logic signed [10:0] e;
    logic [23:0] mr;
    e = s2_q.e;
    if (s2_q.p[47]) begin
      m  = s2_q.p[46:24];
      g  = s2_q.p[23];
      st = |s2_q.p[22:0];
      e  = e + 11'sd1;
    end else begin
      m  = s2_q.p[45:23];
      g  = s2_q.p[22];
      st = |s2_q.p[21:0];
    end
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    if (mr[23]) e = e + 11'sd1;
    if (s2_q.nan)                          res_d = 32'h7FC0_0000;
    else if (s2_q.inf || e >= 11'sd255)    res_d = {s2_q.s, 8'hFF, 23'd0};
    else if (s2_q.zero || e <= 11'sd0)     res_d = {s2_q.s, 31'd0};
    else                                   res_d = {s2_q.s, e[7:0], mr[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      res_q <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      res_q <= res_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_res   = res_q;
endmodule

module mul_chain_seq #(
  parameter  int MUL_LAT = 3,
  parameter  int MAX_OPS = 16,
  parameter  int TAG_W   = 8,
  localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic clk,
  input  logic rst,
  mul_chain_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_OP, BUSY, DONE} state_t;

  localparam int BW = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OPS);

  state_t           state_d, state_q;
  logic [31:0]      acc_d, acc_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic             ovf_d, ovf_q;
  logic             last_d, last_q;
  logic [BW-1:0]    bcnt_d, bcnt_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             accept, fin, mul_issue, mul_vld;
  logic [31:0]      mul_res;

  // Same polarity as this block, so the pipe drains on the same reset.
  mul_3_stage_pipe u_mul (
    .clk      (clk),
    .rst_n    (rst),
    .in_valid (mul_issue),
    .in_op    ({acc_q, bus.in_data}),
    .out_valid(mul_vld),
    .out_res  (mul_res)
  );

  assign accept  = bus.in_valid && in_ready_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign fin     = bus.in_last || (cnt_inc == MAX_C);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    bcnt_d    = '0;
    mul_issue = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        acc_d = bus.in_data;
        tag_d = bus.in_tag;
        cnt_d = CNT_W'(1);
        ovf_d = !bus.in_last && (MAX_OPS == 1);
        state_d = (bus.in_last || MAX_OPS == 1) ? DONE : WAIT_OP;
      end
      WAIT_OP: if (accept) begin
        cnt_d  = cnt_inc;
        ovf_d  = !bus.in_last && (cnt_inc == MAX_C);
        last_d = fin;
`ifdef MUL_CHAIN_ZERO_SKIP_EN
        if (acc_q[30:0] == 31'd0) begin
          acc_d[31] = acc_q[31] ^ bus.in_data[31];
          state_d   = fin ? DONE : WAIT_OP;
        end else begin
          mul_issue = 1'b1;
          state_d   = BUSY;
        end
`else
        mul_issue = 1'b1;
        state_d   = BUSY;
`endif
      end
      BUSY: begin
        bcnt_d = bcnt_q + 1'b1;
        if (mul_vld) begin
          acc_d   = mul_res;
          state_d = last_q ? DONE : WAIT_OP;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE) || (state_d == WAIT_OP);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      bcnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // The strobe must land on the last BUSY cycle or MUL_LAT is misconfigured.
      if (state_q == BUSY && mul_vld) assert (bcnt_q == BW'(MUL_LAT - 1));
      state_q     <= state_d;
      acc_q       <= acc_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_mul_chain_seq.sv
// Directed scoreboard bench for mul_chain_seq (default and MAX_OPS=4 instances).
module tb_mul_chain_seq;
  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  tag;
    logic [4:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic        sel4 = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_tag = '0;
  logic        in_last = 1'b0, in_valid = 1'b0, ordy = 1'b0;
  logic        rdy, ovld, oovf;
  logic [31:0] odata;
  logic [7:0]  otag;
  logic [4:0]  ocnt;

  mul_chain_seq_if #(.TAG_W(8), .CNT_W(5)) bus  ();
  mul_chain_seq_if #(.TAG_W(8), .CNT_W(3)) bus4 ();

  mul_chain_seq #(.MUL_LAT(3), .MAX_OPS(16), .TAG_W(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mul_chain_seq #(.MUL_LAT(3), .MAX_OPS(4),  .TAG_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.in_data   = in_data;   assign bus4.in_data   = in_data;
  assign bus.in_tag    = in_tag;    assign bus4.in_tag    = in_tag;
  assign bus.in_last   = in_last;   assign bus4.in_last   = in_last;
  assign bus.in_valid  = in_valid & ~sel4;
  assign bus4.in_valid = in_valid & sel4;
  assign bus.out_ready  = ordy & ~sel4;
  assign bus4.out_ready = ordy & sel4;
  assign rdy   = sel4 ? bus4.in_ready  : bus.in_ready;
  assign ovld  = sel4 ? bus4.out_valid : bus.out_valid;
  assign odata = sel4 ? bus4.out_data  : bus.out_data;
  assign otag  = sel4 ? bus4.out_tag   : bus.out_tag;
  assign ocnt  = sel4 ? {2'b00, bus4.out_count} : bus.out_count;
  assign oovf  = sel4 ? bus4.out_ovf   : bus.out_ovf;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [7:0] tg, input logic last, output int t_acc);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_tag = tg; in_last = last;
    while (!rdy && n < 200) begin @(negedge clk); n++; end
    if (!rdy) begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1");
    end
    t_acc = cyc;
    @(posedge clk); @(negedge clk);
    if (last) in_valid = 1'b0;
  endtask

  task automatic collect(input int t0, input int lat, input int hold);
    exp_t e;
    int   n = 0;
    while (!ovld && n < 300) begin @(negedge clk); n++; end
    if (!ovld) begin
      errors++;
      $error("FAIL out_valid_timeout: observed out_valid=0 expected 1");
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed unexpected result %h expected none", odata);
      return;
    end
    e = sb.pop_front();
    chk("latency",   32'(cyc - t0), 32'(lat));
    chk("out_data",  odata, e.d);
    chk("out_tag",   {24'd0, otag}, {24'd0, e.tag});
    chk("out_count", {27'd0, ocnt}, {27'd0, e.cnt});
    chk("out_ovf",   {31'd0, oovf}, {31'd0, e.ovf});
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid",    {31'd0, ovld}, 32'd1);
      chk("hold_data",     odata, e.d);
      chk("hold_count",    {27'd0, ocnt}, {27'd0, e.cnt});
      chk("hold_in_ready", {31'd0, rdy}, 32'd0);
    end
    ordy = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy = 1'b0;
    chk("release_valid", {31'd0, ovld}, 32'd0);
  endtask

  initial begin
    int t0, tx;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, rdy},  32'd1);
    chk("rst_out_valid", {31'd0, ovld}, 32'd0);
    chk("rst_out_data",  odata, 32'd0);
    chk("rst_out_tag",   {24'd0, otag}, 32'd0);
    chk("rst_out_count", {27'd0, ocnt}, 32'd0);
    chk("rst_out_ovf",   {31'd0, oovf}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 2*3*4, tags on later operands must be ignored
    sb.push_back('{32'h41C0_0000, 8'h5A, 5'd3, 1'b0});
    send(32'h4000_0000, 8'h5A, 1'b0, t0);
    send(32'h4040_0000, 8'h11, 1'b0, tx);
    send(32'h4080_0000, 8'h22, 1'b1, tx);
    collect(t0, 9, 0);

    // single operand
    sb.push_back('{32'h3F80_0000, 8'h33, 5'd1, 1'b0});
    send(32'h3F80_0000, 8'h33, 1'b1, t0);
    collect(t0, 1, 0);

    // 1.5 * -2.0 with back-pressure in DONE
    sb.push_back('{32'hC040_0000, 8'h7E, 5'd2, 1'b0});
    send(32'h3FC0_0000, 8'h7E, 1'b0, t0);
    send(32'hC000_0000, 8'h00, 1'b1, tx);
    collect(t0, 5, 10);

    // inf * 2.0
    sb.push_back('{32'h7F80_0000, 8'h01, 5'd2, 1'b0});
    send(32'h7F80_0000, 8'h01, 1'b0, t0);
    send(32'h4000_0000, 8'h02, 1'b1, tx);
    collect(t0, 5, 0);

    // reset during BUSY abandons the product
    send(32'h4000_0000, 8'h44, 1'b0, tx);
    send(32'h4040_0000, 8'h44, 1'b1, tx);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready",  {31'd0, rdy},  32'd1);
    chk("midrst_out_valid", {31'd0, ovld}, 32'd0);
    chk("midrst_out_data",  odata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("postrst_no_valid", {31'd0, ovld}, 32'd0);
    chk("postrst_in_ready", {31'd0, rdy},  32'd1);
    sb.push_back('{32'h4040_0000, 8'h66, 5'd2, 1'b0});
    send(32'h3FC0_0000, 8'h66, 1'b0, t0);
    send(32'h4000_0000, 8'h67, 1'b1, tx);
    collect(t0, 5, 0);

    // 0.0 * -5.0 * 7.0 -> -0.0
    sb.push_back('{32'h8000_0000, 8'h0C, 5'd3, 1'b0});
    send(32'h0000_0000, 8'h0C, 1'b0, t0);
    send(32'hC0A0_0000, 8'h0D, 1'b0, tx);
    send(32'h40E0_0000, 8'h0E, 1'b1, tx);
`ifdef MUL_CHAIN_ZERO_SKIP_EN
    collect(t0, 3, 0);
`else
    collect(t0, 9, 0);
`endif

    // MAX_OPS=4 instance: four 2.0s truncate, fifth starts a new product
    sel4 = 1'b1;
    @(negedge clk);
    sb.push_back('{32'h4180_0000, 8'h44, 5'd4, 1'b1});
    send(32'h4000_0000, 8'h44, 1'b0, t0);
    send(32'h4000_0000, 8'h44, 1'b0, tx);
    send(32'h4000_0000, 8'h44, 1'b0, tx);
    send(32'h4000_0000, 8'h44, 1'b0, tx);
    in_valid = 1'b0;
    collect(t0, 13, 0);
    sb.push_back('{32'h4000_0000, 8'h45, 5'd1, 1'b0});
    send(32'h4000_0000, 8'h45, 1'b1, t0);
    collect(t0, 1, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_chain_seq.md
MUL_CHAIN_SEQ -- requirements
Module: mul_chain_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3: latency in cycles of the instantiated fp32 multiplier mul_3_stage_pipe; must equal its real latency.
REQ-002 SHALL have parameter MAX_OPS, default 16: maximum operands per product; CNT_W = clog2(MAX_OPS+1).
REQ-003 SHALL have parameter TAG_W, default 8: width of the node tag carried with each product.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, 32: fp32 operand.
REQ-007 SHALL have port in_tag, input, TAG_W: node tag; sampled with the first operand only.
REQ-008 SHALL have ports in_last, input, 1 (final operand of the product) and in_valid, input, 1 (operand present).
REQ-009 SHALL have port in_ready, output, 1: operand accepted when in_valid && in_ready.
REQ-010 SHALL have ports out_data, output, 32 (fp32 product); out_tag, output, TAG_W; out_count, output, CNT_W (operands consumed).
REQ-011 SHALL have ports out_ovf, output, 1 (MAX_OPS truncation); out_valid, output, 1; out_ready, input, 1.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT_OP, BUSY and DONE.
REQ-013 IDLE: in_ready=1; on accept, acc<=in_data, tag<=in_tag, count<=1; next state is DONE if in_last, else WAIT_OP.
REQ-014 WAIT_OP: in_ready=1; on accept, SHALL issue {acc,in_data} to the multiplier (acc on [63:32]), count+1, and go to BUSY.
REQ-015 BUSY: in_ready=0 for exactly MUL_LAT cycles; on the multiplier output strobe, acc<=product; next state is DONE if the issued operand was last, else WAIT_OP.
REQ-016 Latency: first operand accepted at t0, back-to-back in_valid, N operands -> out_valid SHALL rise at t0+1+(N-1)*(MUL_LAT+1).
REQ-017 DONE: out_valid=1, in_ready=0; out_data, out_tag, out_count and out_ovf SHALL stay stable until out_valid && out_ready; then go to IDLE (no same-cycle accept).
REQ-018 If an accepted operand makes count==MAX_OPS without in_last, it SHALL be treated as last and out_ovf=1 for that result; following operands belong to a new product.
REQ-019 in_valid low in WAIT_OP SHALL stall without any state change; in_data/in_tag SHALL be ignored when in_ready=0.
REQ-020 out_valid SHALL be 0 in every state except DONE.

Reset
REQ-021 rst low SHALL immediately force IDLE with in_ready=1, out_valid=0, out_data=0, out_tag=0, out_count=0, out_ovf=0, acc=0.
REQ-022 Reset mid-operation SHALL abandon the product; the multiplier SHALL be reset together with this block (inverting rst if its polarity differs), so no in-flight product is captured after release.

Configuration
REQ-023 With MUL_CHAIN_ZERO_SKIP_EN defined, a WAIT_OP accept while acc[30:0]==0 SHALL NOT issue a multiply.
- acc[31] ^= in_data[31] and count+1.
- Stay in WAIT_OP (one operand per cycle), or go to DONE next cycle if last.
REQ-024 Without MUL_CHAIN_ZERO_SKIP_EN, every non-first operand SHALL pass through the multiplier per REQ-014/015.
- Zero*NaN then follows multiplier semantics; with the macro it yields signed zero.

Verification
REQ-025 Product 2.0, 3.0, 4.0 (0x40000000, 0x40400000, 0x40800000), tag 0x5A, in_last on the third operand -> at t0+9: out_data=0x41C00000, out_tag=0x5A, out_count=3, out_ovf=0.
REQ-026 Single operand 0x3F800000 with in_last -> out_valid at t0+1, out_data=0x3F800000, out_count=1.
REQ-027 MAX_OPS=4, five operands of 2.0, no in_last -> first result 0x41800000, out_count=4, out_ovf=1; fifth operand starts a new product.
REQ-028 out_ready held low 10 cycles in DONE -> out_valid and outputs stable; in_ready=0 throughout.
REQ-029 rst pulsed low during BUSY -> in_ready=1, out_valid=0 at once; a new 2-operand product 1.5*2.0 -> 0x40400000.
REQ-030 Macro defined, operands 0.0, -5.0, 7.0, last on 7.0 -> out_valid at t0+3, out_data=0x80000000; without macro, out_valid at t0+9, same value.
